// File: rtl/clk_fail_monitor.sv
// Clock-failure monitor: measures two asynchronous clocks against clk and steers a
// glitch-free clock switch select with holdoff. Optional macro: CLK_FAIL_STICKY_EN.
module clk_fail_monitor #(
  parameter int unsigned WINDOW    = 64,
  parameter int unsigned MIN_EDGES = 4,
  parameter int unsigned HOLDOFF   = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic clk_in0,
  input  logic clk_in1,
  input  logic sel_req,
  output logic clk_select,
  output logic clk0_ok,
  output logic clk1_ok,
  output logic switch_busy,
  output logic fail_irq
);

  localparam int unsigned CW = $clog2(WINDOW + 1);
  localparam int unsigned WW = $clog2(WINDOW);
  localparam int unsigned HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]    meta, stab, prev, rise;
  logic [CW-1:0] cnt     [2];
  logic [CW-1:0] cnt_inc [2];
  logic [1:0]    good, ok_q, ok_next;
  logic [WW-1:0] win_cnt;
  logic          win_last;

  logic [1:0]    state, state_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic          sel_nxt, irq_nxt, busy_nxt;
  logic          pref_ok, alt_ok, target;

  // Two-flop synchronizers plus a delay stage for rising-edge detection
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= 2'b00;
      stab <= 2'b00;
      prev <= 2'b00;
    end else begin
      meta <= {clk_in1, clk_in0};
      stab <= meta;
      prev <= stab;
    end
  end

  assign rise     = stab & ~prev;
  assign win_last = (win_cnt == WW'(WINDOW - 1));

  // Saturating edge count including any edge in the current cycle
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_inc[i] = cnt[i];
      if (rise[i] && (cnt[i] != CW'(WINDOW))) cnt_inc[i] = cnt[i] + CW'(1);
      good[i] = (32'(cnt_inc[i]) >= MIN_EDGES);
    end
  end

`ifdef CLK_FAIL_STICKY_EN
  logic [1:0] dead;

  // A flag that has fallen stays low until reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dead <= 2'b00;
    end else if (win_last) begin
      dead <= dead | (ok_q & ~good);
    end
  end

  assign ok_next = good & ~dead;
`else
  assign ok_next = good;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      win_cnt <= '0;
      ok_q    <= 2'b00;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else if (win_last) begin
      win_cnt <= '0;
      ok_q    <= ok_next;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      win_cnt <= win_cnt + WW'(1);
      for (int i = 0; i < 2; i++) cnt[i] <= cnt_inc[i];
    end
  end

  assign clk0_ok = ok_q[0];
  assign clk1_ok = ok_q[1];

  // Preferred clock if healthy, else the other one, else stay put
  assign pref_ok = sel_req ? ok_q[1] : ok_q[0];
  assign alt_ok  = sel_req ? ok_q[0] : ok_q[1];
  assign target  = pref_ok ? sel_req : (alt_ok ? ~sel_req : clk_select);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_INIT;
      clk_select  <= 1'b0;
      hold_cnt    <= '0;
      fail_irq    <= 1'b0;
      switch_busy <= 1'b1;
    end else begin
      state       <= state_nxt;
      clk_select  <= sel_nxt;
      hold_cnt    <= hold_nxt;
      fail_irq    <= irq_nxt;
      switch_busy <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = clk_select;
    hold_nxt  = hold_cnt;
    irq_nxt   = 1'b0;
    case (state)
      ST_INIT: begin
        if (win_last) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (target != clk_select) begin
          sel_nxt   = target;
          hold_nxt  = HW'(HOLDOFF - 1);
          state_nxt = ST_HOLD;
          irq_nxt   = (target != sel_req);
        end
      end
      ST_HOLD: begin
        if (hold_cnt == HW'(0)) state_nxt = ST_RUN;
        else                    hold_nxt  = hold_cnt - HW'(1);
      end
      default: state_nxt = ST_INIT;
    endcase
    busy_nxt = (state_nxt != ST_RUN);
  end

endmodule

// File: tb/tb_clk_fail_monitor.sv
// Scoreboard bench for clk_fail_monitor: a cycle model queues expected outputs,
// plus scenario checks on failover, holdoff, dual failure and reset.
module tb_clk_fail_monitor;

  localparam int unsigned WINDOW    = 64;
  localparam int unsigned MIN_EDGES = 4;
  localparam int unsigned HOLDOFF   = 16;
  localparam int P0 = 8;
  localparam int P1 = 12;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic clk_in0 = 1'b0;
  logic clk_in1 = 1'b0;
  logic sel_req = 1'b0;
  logic clk_select, clk0_ok, clk1_ok, switch_busy, fail_irq;

  clk_fail_monitor #(.WINDOW(WINDOW), .MIN_EDGES(MIN_EDGES), .HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .resetn(resetn), .clk_in0(clk_in0), .clk_in1(clk_in1), .sel_req(sel_req),
    .clk_select(clk_select), .clk0_ok(clk0_ok), .clk1_ok(clk1_ok),
    .switch_busy(switch_busy), .fail_irq(fail_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit m_meta[2], m_stab[2], m_prev[2];
  int m_cnt[2];
  bit m_ok[2], m_dead[2];
  int m_win, m_hold, m_state;
  bit m_sel, m_irq, m_busy;
  logic [4:0] exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_meta[i] = 0; m_stab[i] = 0; m_prev[i] = 0;
      m_cnt[i] = 0; m_ok[i] = 0; m_dead[i] = 0;
    end
    m_win = 0; m_hold = 0; m_state = 0;
    m_sel = 0; m_irq = 0; m_busy = 1;
  endtask

  function automatic logic [4:0] model_vec();
    return {m_sel, m_ok[0], m_ok[1], m_busy, m_irq};
  endfunction

  // One reference clock edge with the inputs currently applied
  task automatic model_step();
    bit e[2];
    bit inp[2];
    bit term, tgt, g;
    if (!resetn) begin
      model_reset();
      return;
    end
    inp[0] = clk_in0; inp[1] = clk_in1;
    for (int i = 0; i < 2; i++) begin
      e[i] = m_stab[i] && !m_prev[i];
      m_prev[i] = m_stab[i];
      m_stab[i] = m_meta[i];
      m_meta[i] = inp[i];
    end
    term = (m_win == WINDOW - 1);
    m_irq = 0;
    if (m_state == 0) begin
      if (term) begin m_state = 1; m_busy = 0; end
    end else if (m_state == 1) begin
      if (m_ok[sel_req]) tgt = sel_req;
      else if (m_ok[!sel_req]) tgt = !sel_req;
      else tgt = m_sel;
      if (tgt != m_sel) begin
        m_sel = tgt; m_hold = HOLDOFF - 1; m_state = 2; m_busy = 1;
        m_irq = (tgt != sel_req);
      end
    end else begin
      if (m_hold == 0) begin m_state = 1; m_busy = 0; end
      else m_hold--;
    end
    for (int i = 0; i < 2; i++) begin
      if (e[i] && m_cnt[i] < WINDOW) m_cnt[i]++;
      if (term) begin
        g = (m_cnt[i] >= MIN_EDGES);
`ifdef CLK_FAIL_STICKY_EN
        if (m_ok[i] && !g) m_dead[i] = 1;
        m_ok[i] = g && !m_dead[i];
`else
        m_ok[i] = g;
`endif
        m_cnt[i] = 0;
      end
    end
    m_win = term ? 0 : m_win + 1;
  endtask

  bit run0 = 0, run1 = 0;
  int ph0 = 0, ph1 = 0;
  int irq_cnt, busy_cnt, rises, falls, sel_hi;
  logic prev_sel;

  task automatic clear_obs();
    irq_cnt = 0; busy_cnt = 0; rises = 0; falls = 0; sel_hi = 0;
    prev_sel = clk_select;
  endtask

  // Predict the coming edge, let it pass, compare, then drive the monitored clocks
  task automatic tick();
    model_step();
    exp_q.push_back(model_vec());
    @(negedge clk);
    if (exp_q.size() > 0)
      check("cycle", 32'({clk_select, clk0_ok, clk1_ok, switch_busy, fail_irq}), 32'(exp_q.pop_front()));
    irq_cnt  += int'(fail_irq);
    busy_cnt += int'(switch_busy);
    sel_hi   += int'(clk_select);
    if (clk_select && !prev_sel) rises++;
    if (!clk_select && prev_sel) falls++;
    prev_sel = clk_select;
    if (run0) ph0 = (ph0 + 1) % P0;
    if (run1) ph1 = (ph1 + 1) % P1;
    clk_in0 = run0 && (ph0 < P0 / 2);
    clk_in1 = run1 && (ph1 < P1 / 2);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    #1;
    check("rst_now", 32'({clk_select, clk0_ok, clk1_ok, switch_busy, fail_irq}), 32'(5'b00010));
    model_reset();
    exp_q.delete();
  endtask

  initial begin
    model_reset();
    #3;
    apply_reset();
    run0 = 1; run1 = 1;
    ticks(3);
    resetn = 1'b1;
    clear_obs();

    // Both clocks healthy, preference 0
    ticks(2 * WINDOW);
    check("ok0_init", 32'(clk0_ok), 32'd1);
    check("ok1_init", 32'(clk1_ok), 32'd1);
    check("busy_init", 32'(switch_busy), 32'd0);
    check("sel_init", 32'(clk_select), 32'd0);
    check("irq_init", 32'(irq_cnt), 32'd0);

    // Lose clk_in0: failover to 1 with one interrupt and one holdoff
    run0 = 0; clear_obs();
    ticks(3 * WINDOW);
    check("ok0_lost", 32'(clk0_ok), 32'd0);
    check("ok1_lost", 32'(clk1_ok), 32'd1);
    check("sel_fail", 32'(clk_select), 32'd1);
    check("irq_fail", 32'(irq_cnt), 32'd1);
    check("busy_fail", 32'(busy_cnt), 32'(HOLDOFF));

    // Restore clk_in0
    run0 = 1; clear_obs();
    ticks(3 * WINDOW);
    check("irq_back", 32'(irq_cnt), 32'd0);
`ifdef CLK_FAIL_STICKY_EN
    check("ok0_back", 32'(clk0_ok), 32'd0);
    check("sel_back", 32'(clk_select), 32'd1);
    check("busy_back", 32'(busy_cnt), 32'd0);
`else
    check("ok0_back", 32'(clk0_ok), 32'd1);
    check("sel_back", 32'(clk_select), 32'd0);
    check("busy_back", 32'(busy_cnt), 32'(HOLDOFF));
`endif

    apply_reset();
    ticks(2);
    resetn = 1'b1;
    ticks(WINDOW + 8);
    check("ok0_rerun", 32'(clk0_ok), 32'd1);
    check("sel_rerun", 32'(clk_select), 32'd0);

    // Short sel_req pulse: one switch, return only after holdoff
    clear_obs();
    sel_req = 1'b1;
    ticks(3);
    sel_req = 1'b0;
    ticks(57);
    check("pulse_rises", 32'(rises), 32'd1);
    check("pulse_falls", 32'(falls), 32'd1);
    check("pulse_hi", 32'(sel_hi), 32'(HOLDOFF + 1));
    check("pulse_irq", 32'(irq_cnt), 32'd0);
    check("pulse_sel", 32'(clk_select), 32'd0);

    // Stop both clocks at a window boundary: flags drop together, select holds
    for (int i = 0; i < 2 * WINDOW && m_win != 0; i++) tick();
    run0 = 0; run1 = 0; clear_obs();
    ticks(3 * WINDOW);
    check("dead_ok0", 32'(clk0_ok), 32'd0);
    check("dead_ok1", 32'(clk1_ok), 32'd0);
    check("dead_sel", 32'(clk_select), 32'd0);
    check("dead_irq", 32'(irq_cnt), 32'd0);
    check("dead_busy", 32'(busy_cnt), 32'd0);

    // Reset in the middle of a holdoff
    run0 = 1; run1 = 1;
    apply_reset();
    ticks(2);
    resetn = 1'b1;
    ticks(WINDOW + 8);
    sel_req = 1'b1;
    ticks(5);
    check("hold_sel", 32'(clk_select), 32'd1);
    check("hold_busy", 32'(switch_busy), 32'd1);
    apply_reset();
    ticks(3);
    resetn = 1'b1;
    ticks(10);
    check("partial_ok0", 32'(clk0_ok), 32'd0);
    check("partial_busy", 32'(switch_busy), 32'd1);
    ticks(WINDOW + 8);
    check("final_sel", 32'(clk_select), 32'd1);
    check("final_ok1", 32'(clk1_ok), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_fail_monitor.md
CLK_FAIL_MONITOR -- requirements
Module: clk_fail_monitor

Interface
REQ-001 SHALL have parameter WINDOW, default 64: reference cycles per measurement window (>=8).
REQ-002 SHALL have parameter MIN_EDGES, default 4: minimum synchronized rising edges per window for a clock to be declared good.
REQ-003 SHALL have parameter HOLDOFF, default 16: reference cycles after any clk_select change during which no further change occurs.
REQ-004 SHALL have port clk, input, 1: free-running reference clock; all logic is in this domain.
REQ-005 SHALL have port resetn, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port clk_in0, input, 1: monitored clock 0; asynchronous to clk.
REQ-007 SHALL have port clk_in1, input, 1: monitored clock 1; asynchronous to clk.
REQ-008 SHALL have port sel_req, input, 1: preferred source (0 = clk_in0, 1 = clk_in1); synchronous to clk.
REQ-009 SHALL have port clk_select, output, 1: registered select that drives the downstream glitch-free clock switch.
REQ-010 SHALL have ports clk0_ok and clk1_ok, output, 1 each: per-clock health flags.
REQ-011 SHALL have port switch_busy, output, 1: high during INIT and HOLDOFF states.
REQ-012 SHALL have port fail_irq, output, 1: one-cycle pulse on every failover-driven select change.

Function
REQ-013 SHALL pass each clk_inN through a 2-flop synchronizer, then detect rising edges; monitored clocks are required to be slower than clk/2.
REQ-014 SHALL count edges per clock in saturating counters sized to hold WINDOW.
REQ-015 SHALL run a window counter 0..WINDOW-1 that wraps; on the terminal cycle (inclusive of any edge in that cycle), clkN_ok <= (count >= MIN_EDGES), and edge counters clear to 0 for the next window.
REQ-016 SHALL implement FSM states INIT, RUN and HOLD.
REQ-017 INIT SHALL last until the first window completes, then enter RUN; clk_select is not changed in INIT.
REQ-018 In RUN, target SHALL be: sel_req if that clock is ok; else the other clock if it is ok; else the current clk_select (hold when both clocks are bad).
REQ-019 When target != clk_select in RUN: clk_select <= target, load the holdoff counter with HOLDOFF-1, and enter HOLD.
REQ-020 fail_irq SHALL pulse in the same cycle as the change if target != sel_req (failover); changes back to sel_req, or changes caused only by sel_req, do not pulse.
REQ-021 HOLD SHALL count down to 0, then return to RUN; sel_req changes and health changes arriving during HOLD are evaluated on the first RUN cycle.
REQ-022 Health updates SHALL continue in every state; a window terminal cycle that coincides with a RUN decision uses the pre-update ok values.

Reset
REQ-023 Assertion of resetn low SHALL immediately force: clk_select=0, clk0_ok=0, clk1_ok=0, switch_busy=1, fail_irq=0, all counters 0, synchronizers 0, state INIT.
REQ-024 Reset mid-window or mid-HOLD SHALL discard all partial counts; deassertion restarts a full INIT window.

Configuration
REQ-025 Macro CLK_FAIL_STICKY_EN: when defined, a clkN_ok that has gone 1->0 remains 0 until resetn, regardless of later good windows; when undefined, clkN_ok recovers after one good window.

Verification
REQ-026 WINDOW=64, MIN_EDGES=4; clk_in0 period 8 clk, clk_in1 period 12 clk, sel_req=0 -> after the first window clk0_ok=clk1_ok=1, switch_busy=0, clk_select=0, no fail_irq.
REQ-027 Same setup, stop clk_in0 -> at the end of the next full window clk0_ok=0; the next cycle clk_select=1 and fail_irq pulses once; switch_busy high for 16 cycles.
REQ-028 Restart clk_in0 (sticky undefined) -> clk0_ok=1 after one good window; clk_select returns to 0 without fail_irq.
REQ-029 Toggle sel_req 0->1->0 within 5 cycles while in RUN -> a single change to 1; the return to 0 occurs only after HOLD (16 cycles) expires.
REQ-030 Stop both clocks -> both ok flags 0; clk_select holds its value; no fail_irq.
REQ-031 With CLK_FAIL_STICKY_EN defined, repeat REQ-028 -> clk0_ok stays 0 and clk_select stays 1 until resetn is pulsed; assert resetn mid-HOLD -> all outputs take their reset values at once.
